ekf_stage_seq: RTL

//  Initiator side of the RSA stage/nonlinear handshakes. Accepts one EKF command
//  (PRD / NEW / UPD), issues it to RSA on stage_val, then plays the nonlinear-unit
//  end: supplies nonlinear data (s_val) and drains RSA's result (s_rdy). Owns the

---
 rtl/ekf_pkg.sv | 27 ++
 rtl/ekf_stage_seq_watchdog.sv | 25 ++
 rtl/ekf_stage_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ekf_pkg.sv
// Shared encodings for the EKF stage sequencer: stage one-hots, error codes
// and FSM states.
package ekf_pkg;

  localparam logic [2:0] IDLE      = 3'b000;
  localparam logic [2:0] STAGE_PRD = 3'b001;
  localparam logic [2:0] STAGE_NEW = 3'b010;
  localparam logic [2:0] STAGE_UPD = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_NL_EVAL = 3'd2,
    S_NL_SEND = 3'd3,
    S_NL_RECV = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  function automatic logic is_stage(input logic [2:0] v);
    return (v == STAGE_PRD) || (v == STAGE_NEW) || (v == STAGE_UPD);
  endfunction

endpackage

// File: rtl/ekf_stage_seq_watchdog.sv
// Per-state wait watchdog: counts cycles spent in one wait state and flags
// the cycle whose closing edge brings the count to 2**TO_W-1.
module seq_watchdog #(
  parameter int TO_W = 12
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst)        cnt <= '0;
    else if (clr || !en) cnt <= '0;
    else                 cnt <= cnt + TO_W'(1);
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ekf_stage_seq.sv
// EKF stage sequencer: issues one PRD/NEW/UPD command to RSA, then acts as the
// nonlinear-unit end of the RSA handshakes. Owns the landmark count.
module ekf_stage_seq
  import ekf_pkg::*;
#(
  parameter int ROW_LEN = 10,
  parameter int LM_MAX  = 511,
  parameter int TO_W    = 12
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_val,
  input  logic [2:0]         cmd_stage,
  input  logic [ROW_LEN-1:0] cmd_lk,
  output logic               cmd_rdy,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] l_k,
  output logic               nl_start,
  input  logic               nl_done,
  output logic [2:0]         nonlinear_s_val,
  input  logic [2:0]         nonlinear_m_rdy,
  input  logic [2:0]         nonlinear_m_val,
  output logic [2:0]         nonlinear_s_rdy,
  output logic               done,
  output logic [1:0]         err,
  output logic [2:0]         dbg_state
);

  // Handshakes: a transfer happens on the edge where our registered bit and
  // the partner bit are both 1. Our bits only ever carry the latched stage, so
  // masking by them discards partner bits belonging to other stages.

  state_t     state, next_state;
  logic [2:0] stage_q;
  logic       accept, reject, timeout, cmd_bad;
  logic       wd_en, wd_clr, wd_expire;

  assign cmd_bad = !is_stage(cmd_stage)
                || ((cmd_stage == STAGE_UPD) && (cmd_lk >= landmark_num))
                || ((cmd_stage == STAGE_NEW) && (landmark_num == ROW_LEN'(LM_MAX)));

  assign wd_en  = (state == S_REQ) || (state == S_NL_EVAL)
               || (state == S_NL_SEND) || (state == S_NL_RECV);
  assign wd_clr = (next_state != state);
  assign dbg_state = state;

  seq_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk    (clk),
    .sys_rst(sys_rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_val) begin
          if (cmd_bad) reject = 1'b1;
          else begin
            accept     = 1'b1;
            next_state = S_REQ;
          end
        end
      end
      S_REQ:     if (|(stage_val & stage_rdy))             next_state = S_NL_EVAL;
      S_NL_EVAL: if (nl_done)                              next_state = S_NL_SEND;
      S_NL_SEND: if (|(nonlinear_s_val & nonlinear_m_rdy)) next_state = S_NL_RECV;
      S_NL_RECV: if (|(nonlinear_s_rdy & nonlinear_m_val)) next_state = S_FIN;
      S_FIN:     next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    // A transfer on the expiry edge still wins over the timeout.
    if (wd_expire && (next_state == state)) begin
      timeout    = 1'b1;
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cmd_rdy         <= 1'b1;
      stage_val       <= IDLE;
      nl_start        <= 1'b0;
      nonlinear_s_val <= IDLE;
      nonlinear_s_rdy <= IDLE;
      done            <= 1'b0;
      err             <= ERR_NONE;
      stage_q         <= IDLE;
      l_k             <= '0;
      landmark_num    <= '0;
    end else begin
      cmd_rdy         <= (next_state == S_IDLE);
      stage_val       <= (next_state == S_REQ) ? (accept ? cmd_stage : stage_q) : IDLE;
      nl_start        <= (state == S_REQ) && (next_state == S_NL_EVAL);
      nonlinear_s_val <= (next_state == S_NL_SEND) ? stage_q : IDLE;
      nonlinear_s_rdy <= (next_state == S_NL_RECV) ? stage_q : IDLE;
      done            <= (state == S_FIN);
      if ((state == S_IDLE) && cmd_val) begin
        stage_q <= cmd_stage;
        l_k     <= cmd_lk;
      end
      // Only a completed NEW grows the map; LM_MAX is guarded at accept time.
      if ((state == S_FIN) && (stage_q == STAGE_NEW))
        landmark_num <= landmark_num + ROW_LEN'(1);
      if (accept)       err <= ERR_NONE;
      else if (reject)  err <= ERR_BAD_CMD;
      else if (timeout) err <= ERR_TIMEOUT;
    end
  end

endmodule
